// File: rtl/avst_pkt_gen.sv
// Avalon-ST packet source: emits one packet per accepted start command with
// an incrementing data pattern (seed + beat index), a latched channel, and
// sop/eop/empty sideband. Honours avst_ready_i with readyLatency 0; every
// stream output is registered and holds while the sink stalls.
module avst_pkt_gen #(
  parameter int channel_width = 4,
  parameter int data_width    = 32,
  parameter int empty_width   = 2,
  parameter int len_width     = 16
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     start_i,
  input  logic [len_width-1:0]     len_i,
  input  logic [channel_width-1:0] channel_i,
  input  logic [data_width-1:0]    seed_i,
  output logic                     busy_o,
  output logic                     done_o,
  output logic [channel_width-1:0] avst_channel_o,
  output logic                     avst_sop_o,
  output logic                     avst_eop_o,
  output logic [empty_width-1:0]   avst_empty_o,
  output logic [data_width-1:0]    avst_data_o,
  output logic                     avst_valid_o,
  input  logic                     avst_ready_i
);

  localparam int BYTES = data_width / 8;
  localparam int LOG2B = $clog2(BYTES);
  // Rounding term for ceil(len / BYTES); one extra bit keeps len near the
  // top of its range from overflowing before the shift.
  localparam logic [len_width:0] BYTES_M1  = (len_width + 1)'(BYTES - 1);
  localparam logic [len_width:0] BEATS_ONE = (len_width + 1)'(1);

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_e;

  state_e                   state_q,      state_d;
  logic [len_width-1:0]     beat_q,       beat_d;
  logic [len_width-1:0]     beats_q,      beats_d;
  logic [empty_width-1:0]   last_empty_q, last_empty_d;
  logic [channel_width-1:0] channel_q,    channel_d;
  logic [data_width-1:0]    data_q,       data_d;
  logic [empty_width-1:0]   empty_q,      empty_d;
  logic                     sop_q,        sop_d;
  logic                     eop_q,        eop_d;
  logic                     valid_q,      valid_d;
  logic                     busy_q,       busy_d;
  logic                     done_q,       done_d;

  logic [len_width:0]       beats_ext;
  logic [len_width:0]       pad_ext;
  logic [len_width-1:0]     beat_inc;
  logic [len_width-1:0]     last_idx;
  logic                     next_is_last;

  // Packet geometry for the command currently on the start inputs, and the
  // index arithmetic used to flag the eop beat one step ahead.
  assign beats_ext    = ({1'b0, len_i} + BYTES_M1) >> LOG2B;
  assign pad_ext      = (beats_ext << LOG2B) - {1'b0, len_i};
  assign beat_inc     = beat_q + 1'b1;
  assign last_idx     = beats_q - 1'b1;
  assign next_is_last = (beat_inc == last_idx);

  // Next-state and next-output logic for the IDLE/SEND packet sequencer.
  always_comb begin
    // NOTE: every _d defaults to its _q (hold) so no path through the case
    // below can leave a signal unassigned and infer a latch.
    state_d      = state_q;
    beat_d       = beat_q;
    beats_d      = beats_q;
    last_empty_d = last_empty_q;
    channel_d    = channel_q;
    data_d       = data_q;
    empty_d      = empty_q;
    sop_d        = sop_q;
    eop_d        = eop_q;
    valid_d      = valid_q;
    busy_d       = busy_q;
    done_d       = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (start_i && (len_i != '0)) begin
          state_d      = SEND;
          busy_d       = 1'b1;
          beat_d       = '0;
          beats_d      = beats_ext[len_width-1:0];
          last_empty_d = pad_ext[empty_width-1:0];
          channel_d    = channel_i;
          data_d       = seed_i;
          valid_d      = 1'b1;
          sop_d        = 1'b1;
          eop_d        = (beats_ext == BEATS_ONE);
          empty_d      = (beats_ext == BEATS_ONE) ? pad_ext[empty_width-1:0] : '0;
        end
      end
      SEND: begin
        // start_i is deliberately not looked at here, even on the eop beat.
        if (avst_ready_i) begin
          if (eop_q) begin
            state_d = IDLE;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            valid_d = 1'b0;
            sop_d   = 1'b0;
            eop_d   = 1'b0;
          end else begin
            beat_d  = beat_inc;
            data_d  = data_q + 1'b1;
            sop_d   = 1'b0;
            eop_d   = next_is_last;
            empty_d = next_is_last ? last_empty_q : '0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // State and output registers; asynchronous reset abandons any packet.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= IDLE;
      beat_q       <= '0;
      beats_q      <= '0;
      last_empty_q <= '0;
      channel_q    <= '0;
      data_q       <= '0;
      empty_q      <= '0;
      sop_q        <= 1'b0;
      eop_q        <= 1'b0;
      valid_q      <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
    end else begin
      // NOTE: non-blocking assignments so every flop samples the pre-edge
      // values regardless of statement order.
      state_q      <= state_d;
      beat_q       <= beat_d;
      beats_q      <= beats_d;
      last_empty_q <= last_empty_d;
      channel_q    <= channel_d;
      data_q       <= data_d;
      empty_q      <= empty_d;
      sop_q        <= sop_d;
      eop_q        <= eop_d;
      valid_q      <= valid_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
    end
  end

  assign busy_o         = busy_q;
  assign done_o         = done_q;
  assign avst_channel_o = channel_q;
  assign avst_sop_o     = sop_q;
  assign avst_eop_o     = eop_q;
  assign avst_empty_o   = empty_q;
  assign avst_data_o    = data_q;
  assign avst_valid_o   = valid_q;

endmodule

// File: tb/tb_avst_pkt_gen.sv
// Self-checking bench for avst_pkt_gen: a table of directed packets, hand
// sequences for stall / ignored-start / reset corners, and random packets
// with random backpressure, all scored against a beat-list reference model.
module tb_avst_pkt_gen;

  localparam int CW    = 4;
  localparam int DW    = 32;
  localparam int EW    = 2;
  localparam int LW    = 16;
  localparam int BYTES = DW / 8;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          start_i;
  logic [LW-1:0] len_i;
  logic [CW-1:0] channel_i;
  logic [DW-1:0] seed_i;
  logic          busy_o;
  logic          done_o;
  logic [CW-1:0] avst_channel_o;
  logic          avst_sop_o;
  logic          avst_eop_o;
  logic [EW-1:0] avst_empty_o;
  logic [DW-1:0] avst_data_o;
  logic          avst_valid_o;
  logic          avst_ready_i;

  avst_pkt_gen #(
    .channel_width(CW),
    .data_width   (DW),
    .empty_width  (EW),
    .len_width    (LW)
  ) dut (
    .clk           (clk),
    .reset_n       (reset_n),
    .start_i       (start_i),
    .len_i         (len_i),
    .channel_i     (channel_i),
    .seed_i        (seed_i),
    .busy_o        (busy_o),
    .done_o        (done_o),
    .avst_channel_o(avst_channel_o),
    .avst_sop_o    (avst_sop_o),
    .avst_eop_o    (avst_eop_o),
    .avst_empty_o  (avst_empty_o),
    .avst_data_o   (avst_data_o),
    .avst_valid_o  (avst_valid_o),
    .avst_ready_i  (avst_ready_i)
  );

  always #5 clk = ~clk;

  // Beat image: {channel, sop, eop, empty, data}
  typedef logic [CW+2+EW+DW-1:0] beat_t;

  int    checks = 0;
  int    errors = 0;
  beat_t exp_q[$];
  int    xfer_cnt;
  logic [DW-1:0] last_data;
  logic [EW-1:0] last_empty;
  bit    done_exp;
  bit    prev_stall;
  beat_t prev_beat;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: the full list of beats a packet must produce.
  task automatic model_push(input int len, input logic [DW-1:0] seed, input logic [CW-1:0] ch);
    int nb;
    logic [DW-1:0] d;
    logic [EW-1:0] emp;
    nb = (len + BYTES - 1) / BYTES;
    for (int k = 0; k < nb; k++) begin
      d   = seed + DW'(k);
      emp = (k == nb - 1) ? EW'(nb * BYTES - len) : '0;
      exp_q.push_back({ch, (k == 0), (k == nb - 1), emp, d});
    end
  endtask

  // Stream monitor: scores transfers, stall stability, done and busy.
  always @(negedge clk) begin
    beat_t cur;
    if (!reset_n) begin
      prev_stall = 1'b0;
      done_exp   = 1'b0;
    end else begin
      cur = {avst_channel_o, avst_sop_o, avst_eop_o, avst_empty_o, avst_data_o};
      check("busy_vs_valid", 64'(busy_o), 64'(avst_valid_o));
      check("done_pulse", 64'(done_o), 64'(done_exp));
      if (prev_stall) check("hold_stable", 64'(cur), 64'(prev_beat));
      if (avst_valid_o && avst_ready_i) begin
        if (exp_q.size() == 0) check("unexpected_beat", 64'(cur), 64'(0));
        else check("beat", 64'(cur), 64'(exp_q.pop_front()));
        xfer_cnt++;
        if (avst_eop_o) begin
          last_data  = avst_data_o;
          last_empty = avst_empty_o;
        end
      end
      done_exp   = avst_valid_o && avst_ready_i && avst_eop_o;
      prev_stall = avst_valid_o && !avst_ready_i;
      prev_beat  = cur;
    end
  end

  // Called at a negedge; returns at the negedge where done_o is seen.
  task automatic wait_done(input bit rnd_ready);
    bit got = 1'b0;
    for (int c = 0; c < 400; c++) begin
      if (done_o) begin
        got = 1'b1;
        break;
      end
      @(posedge clk); #1;
      avst_ready_i = rnd_ready ? ($urandom_range(0, 3) != 0) : 1'b1;
      @(negedge clk);
    end
    check("done_seen", 64'(got), 64'(1));
    check("no_lost_beats", 64'(exp_q.size()), 64'(0));
  endtask

  // Issue one start command; b2b drives start right away (from the done cycle).
  task automatic run_pkt(input int len, input logic [DW-1:0] seed, input logic [CW-1:0] ch,
                         input bit rnd_ready, input bit b2b);
    model_push(len, seed, ch);
    xfer_cnt = 0;
    if (!b2b) begin
      @(posedge clk); #1;
    end
    start_i = 1'b1; len_i = LW'(len); seed_i = seed; channel_i = ch;
    @(posedge clk); #1;
    start_i = 1'b0; len_i = LW'($urandom); seed_i = $urandom; channel_i = CW'($urandom);
    @(negedge clk);
    if (len == 0) begin
      repeat (3) @(negedge clk);
      check("len0_idle", 64'({avst_valid_o, busy_o}), 64'(0));
    end else begin
      check("start_latency", 64'({avst_valid_o, avst_sop_o, busy_o}), 64'(3'b111));
      wait_done(rnd_ready);
    end
  endtask

  typedef struct {
    int            len;
    logic [DW-1:0] seed;
    logic [CW-1:0] ch;
    int            exp_beats;
    logic [EW-1:0] exp_empty;
    logic [DW-1:0] exp_last;
  } vec_t;

  vec_t vecs[6];

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    vecs[0] = '{10, 32'h100,      4'd3,  3, 2'd2, 32'h102};
    vecs[1] = '{4,  32'h55,       4'd1,  1, 2'd0, 32'h55};
    vecs[2] = '{1,  32'hA,        4'd2,  1, 2'd3, 32'hA};
    vecs[3] = '{8,  32'hFFFFFFFF, 4'd5,  2, 2'd0, 32'h0};
    vecs[4] = '{13, 32'h7,        4'd0,  4, 2'd3, 32'hA};
    vecs[5] = '{5,  32'h0,        4'd15, 2, 2'd3, 32'h1};

    reset_n = 1'b0; start_i = 1'b0; len_i = '0; channel_i = '0; seed_i = '0;
    avst_ready_i = 1'b1;
    #3;
    check("reset_outputs",
          64'({avst_valid_o, avst_sop_o, avst_eop_o, busy_o, done_o,
               avst_channel_o, avst_empty_o, avst_data_o}), 64'(0));
    @(negedge clk); #2 reset_n = 1'b1;

    // Directed table; every packet after the first starts in the done cycle.
    for (int i = 0; i < 6; i++) begin
      run_pkt(vecs[i].len, vecs[i].seed, vecs[i].ch, 1'b0, i > 0);
      check("tbl_beats", 64'(xfer_cnt), 64'(vecs[i].exp_beats));
      check("tbl_empty", 64'(last_empty), 64'(vecs[i].exp_empty));
      check("tbl_last_data", 64'(last_data), 64'(vecs[i].exp_last));
    end

    // Backpressure: ready low for 3 cycles while beat 1 is presented.
    model_push(12, 32'h200, 4'd6);
    xfer_cnt = 0;
    @(posedge clk); #1;
    start_i = 1'b1; len_i = 16'd12; seed_i = 32'h200; channel_i = 4'd6;
    @(posedge clk); #1;
    start_i = 1'b0;
    @(posedge clk); #1;
    avst_ready_i = 1'b0;
    for (int c = 0; c < 3; c++) begin
      @(negedge clk);
      check("stall_beat1", 64'({avst_valid_o, avst_sop_o, avst_data_o}), 64'({2'b10, 32'h201}));
    end
    avst_ready_i = 1'b1;
    wait_done(1'b0);
    check("stall_beats", 64'(xfer_cnt), 64'(3));
    check("stall_empty", 64'(last_empty), 64'(0));

    // Start held through a whole packet (incl. the eop edge) with other
    // parameters, then a zero-length start in IDLE: both must be ignored.
    model_push(20, 32'h500, 4'd4);
    xfer_cnt = 0;
    @(posedge clk); #1;
    start_i = 1'b1; len_i = 16'd20; seed_i = 32'h500; channel_i = 4'd4;
    @(posedge clk); #1;
    len_i = 16'd4; seed_i = 32'hDEAD; channel_i = 4'd9;
    @(negedge clk);
    wait_done(1'b0);
    start_i = 1'b0;
    check("ignore_beats", 64'(xfer_cnt), 64'(5));
    repeat (3) @(negedge clk);
    check("ignore_idle", 64'({avst_valid_o, busy_o}), 64'(0));
    run_pkt(0, 32'h1, 4'd1, 1'b0, 1'b0);

    // Reset during beat 2 of a 5-beat packet.
    model_push(20, 32'h300, 4'd3);
    @(posedge clk); #1;
    start_i = 1'b1; len_i = 16'd20; seed_i = 32'h300; channel_i = 4'd3;
    @(posedge clk); #1;
    start_i = 1'b0;
    repeat (3) @(negedge clk);
    check("pre_reset_beat2", 64'(avst_data_o), 64'(32'h302));
    #2 reset_n = 1'b0;
    #1;
    check("midpkt_reset",
          64'({avst_valid_o, avst_sop_o, avst_eop_o, busy_o, done_o,
               avst_channel_o, avst_empty_o, avst_data_o}), 64'(0));
    exp_q.delete();
    @(negedge clk); #2 reset_n = 1'b1;
    run_pkt(8, 32'h400, 4'd1, 1'b0, 1'b0);
    check("post_reset_beats", 64'(xfer_cnt), 64'(2));

    // Random packets with random backpressure.
    for (int i = 0; i < 30; i++) begin
      run_pkt($urandom_range(0, 40), $urandom, CW'($urandom), 1'b1, $urandom_range(0, 1) == 1);
    end
    avst_ready_i = 1'b1;
    repeat (3) @(negedge clk);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
